// File: rtl/pe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pe_ctrl_pkg
// Purpose : Shared PE control codes, sequencer state encoding and default
//           widths used by pe, pe_sequencer and the array scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package pe_ctrl_pkg;

  // Default geometry
  localparam int DEF_MAC_LATENCY = 4;
  localparam int DEF_LEN_W       = 12;
  localparam int DEF_VEC_W       = 8;
  localparam int CTRL_W          = 3;

  // PE control codes; 6 and 7 are reserved and never driven
  localparam logic [CTRL_W-1:0] CTRL_NOP       = 3'd0;
  localparam logic [CTRL_W-1:0] CTRL_LDW       = 3'd1;
  localparam logic [CTRL_W-1:0] CTRL_MAC_FIRST = 3'd2;
  localparam logic [CTRL_W-1:0] CTRL_MAC_ACC   = 3'd3;
  localparam logic [CTRL_W-1:0] CTRL_ACT       = 3'd4;
  localparam logic [CTRL_W-1:0] CTRL_RD        = 3'd5;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADW = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ACT   = 3'd4,
    ST_OUT   = 3'd5,
    ST_FIN   = 3'd6
  } pe_state_t;

endpackage
`default_nettype wire

// File: rtl/pe_sequencer_beat_counter.sv
`default_nettype none
// ============================================================================
// Module  : beat_counter
// Purpose : Counter with a loadable terminal value. Counts accepted beats,
//           flags the terminal beat and returns to zero after it, so the
//           count never exceeds the loaded terminal value.
// Revision: 1.0 - initial release
// ============================================================================
module beat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_last,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_last
);

  logic [W-1:0] r_count;
  logic [W-1:0] r_last;

  assign o_count = r_count;
  assign o_last  = (r_count == r_last);

  // Load clears the count and captures the terminal value; each beat advances,
  // folding back to zero on the terminal beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_last  <= '0;
    end else if (i_load) begin
      r_count <= '0;
      r_last  <= i_last;
    end else if (i_inc) begin
      r_count <= o_last ? '0 : r_count + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pe_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pe_sequencer
// Purpose : Command-driven controller sequencing one PE through weight load,
//           multiply-accumulate, drain, optional activation and readout,
//           gating the shared data bus with a valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module pe_sequencer
  import pe_ctrl_pkg::*;
#(
  parameter int MAC_LATENCY = DEF_MAC_LATENCY,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int VEC_W       = DEF_VEC_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [LEN_W-1:0]  CmdLen,
  input  logic [VEC_W-1:0]  CmdVecs,
  input  logic              CmdAct,
  input  logic              DataValid,
  output logic              DataReady,
  output logic [CTRL_W-1:0] Ctrl,
  output logic              OutputCtrl,
  output logic              EnableAct,
  output logic              ResultValid,
  input  logic              ResultReady,
  output logic              Busy,
  output logic              Done
);

  localparam logic [3:0] c_drain_last = 4'(MAC_LATENCY - 1);

  pe_state_t        r_state;
  pe_state_t        w_next;
  logic             r_cmd_ready;
  logic             r_done;
  logic             r_act;
  logic [3:0]       r_drain;

  logic             w_accept;
  logic             w_degenerate;
  logic             w_beat;
  logic             w_rd_hs;
  logic [LEN_W-1:0] w_word_count;
  logic             w_word_last;
  logic [VEC_W-1:0] w_unused_vec_count;
  logic             w_vec_last;

  assign w_accept     = CmdValid && r_cmd_ready && (r_state == ST_IDLE);
  assign w_degenerate = (CmdLen == '0) || (CmdVecs == '0);
  assign w_beat       = DataValid && DataReady;
  assign w_rd_hs      = (r_state == ST_OUT) && ResultReady;

  // Word counter: beats within the weight load and within each vector
  beat_counter #(.W(LEN_W)) u_word_cnt (
    .clk     (Clock),
    .rst     (Reset),
    .i_load  (w_accept),
    .i_last  (CmdLen - LEN_W'(1)),
    .i_inc   (w_beat),
    .o_count (w_word_count),
    .o_last  (w_word_last)
  );

  // Vector counter: advanced by each result readout handshake
  beat_counter #(.W(VEC_W)) u_vec_cnt (
    .clk     (Clock),
    .rst     (Reset),
    .i_load  (w_accept),
    .i_last  (CmdVecs - VEC_W'(1)),
    .i_inc   (w_rd_hs),
    .o_count (w_unused_vec_count),
    .o_last  (w_vec_last)
  );

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = w_degenerate ? ST_FIN : ST_LOADW;
      ST_LOADW: if (w_beat && w_word_last) w_next = ST_MAC;
      ST_MAC:   if (w_beat && w_word_last) w_next = ST_DRAIN;
      ST_DRAIN: if (r_drain == c_drain_last) w_next = r_act ? ST_ACT : ST_OUT;
      ST_ACT:   w_next = ST_OUT;
      ST_OUT:   if (ResultReady) w_next = w_vec_last ? ST_FIN : ST_MAC;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Output decode; codes track the data beat in the same cycle
  always_comb begin
    Ctrl        = CTRL_NOP;
    DataReady   = 1'b0;
    OutputCtrl  = 1'b0;
    EnableAct   = 1'b0;
    ResultValid = 1'b0;
    case (r_state)
      ST_LOADW: begin
        DataReady = 1'b1;
        if (DataValid) Ctrl = CTRL_LDW;
      end
      ST_MAC: begin
        DataReady = 1'b1;
        if (DataValid) Ctrl = (w_word_count == '0) ? CTRL_MAC_FIRST : CTRL_MAC_ACC;
      end
      ST_ACT: begin
        Ctrl      = CTRL_ACT;
        EnableAct = 1'b1;
      end
      ST_OUT: begin
        Ctrl        = CTRL_RD;
        OutputCtrl  = 1'b1;
        ResultValid = 1'b1;
      end
      default: ;
    endcase
  end

  // Drain timer restarts whenever the FSM is outside DRAIN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                  r_drain <= '0;
    else if (r_state != ST_DRAIN) r_drain <= '0;
    else                        r_drain <= r_drain + 4'd1;
  end

  // Command fields latch, ready flag and completion pulse
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_act       <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_accept) r_act <= CmdAct;
      r_cmd_ready <= (w_next == ST_IDLE);
      r_done      <= (r_state == ST_FIN);
    end
  end

  assign CmdReady = r_cmd_ready;
  assign Done     = r_done;
  assign Busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pe_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pe_sequencer
// Purpose : Self-checking bench for pe_sequencer. Expected control-code
//           streams and latencies come from a command-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pe_sequencer;

  localparam int LAT   = 4;
  localparam int LEN_W = 12;
  localparam int VEC_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [VEC_W-1:0] cmd_vecs = '0;
  logic             cmd_act = 1'b0;
  logic             data_valid = 1'b0;
  logic             data_ready;
  logic [2:0]       ctrl;
  logic             output_ctrl;
  logic             enable_act;
  logic             result_valid;
  logic             result_ready = 1'b0;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_pass   = 0;

  pe_sequencer #(.MAC_LATENCY(LAT), .LEN_W(LEN_W), .VEC_W(VEC_W)) dut (
    .Clock       (clk),
    .Reset       (rst),
    .CmdValid    (cmd_valid),
    .CmdReady    (cmd_ready),
    .CmdLen      (cmd_len),
    .CmdVecs     (cmd_vecs),
    .CmdAct      (cmd_act),
    .DataValid   (data_valid),
    .DataReady   (data_ready),
    .Ctrl        (ctrl),
    .OutputCtrl  (output_ctrl),
    .EnableAct   (enable_act),
    .ResultValid (result_valid),
    .ResultReady (result_ready),
    .Busy        (busy),
    .Done        (done)
  );

  always #5 clk = ~clk;

  // Accept cycle is cycle 0; Done is registered off the FIN cycle.
  function automatic int model_latency(input int n, input int m, input int act);
    if (n == 0 || m == 0) return 2;
    return n + m * (n + LAT + act + 1) + 2;
  endfunction

  // One command from accept to Done, checked against the model.
  // dv_mode: 0 = DataValid held high, 1 = toggling, 2 = random.
  task automatic run_cmd(input string name, input int n, input int m, input int act,
                         input int dv_mode, input int rr_stall, input bit inject,
                         input bit chk_lat);
    int  exp_q[$];
    int  got_q[$];
    int  lat = 0;
    int  acts = 0;
    int  rd_cycles = 0;
    int  viol = 0;
    int  stall_cnt = 0;
    int  budget;
    int  bad_idx = -1;
    bit  seen_done = 1'b0;
    bit  nondeg;
    nondeg = (n > 0) && (m > 0);
    if (nondeg) begin
      repeat (n) exp_q.push_back(1);
      for (int v = 0; v < m; v++) begin
        exp_q.push_back(2);
        for (int k = 1; k < n; k++) exp_q.push_back(3);
        if (act != 0) exp_q.push_back(4);
        exp_q.push_back(5);
      end
    end
    budget = 4 * (model_latency(n, m, act) + m * (rr_stall + 1)) + 50;

    @(posedge clk); #1;
    cmd_len      = LEN_W'(n);
    cmd_vecs     = VEC_W'(m);
    cmd_act      = act[0];
    cmd_valid    = 1'b1;
    data_valid   = 1'b0;
    result_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL %s cmd_ready_before_accept got=%b exp=1", name, cmd_ready);
    else n_pass++;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_len   = LEN_W'($urandom);
    cmd_vecs  = VEC_W'($urandom);
    cmd_act   = 1'($urandom);

    while (!seen_done && lat < budget) begin
      lat++;
      case (dv_mode)
        0:       data_valid = 1'b1;
        1:       data_valid = lat[0];
        default: data_valid = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (result_valid === 1'b1) begin
        result_ready = (stall_cnt >= rr_stall);
        stall_cnt++;
      end else begin
        result_ready = 1'($urandom_range(0, 1));
        stall_cnt    = 0;
      end
      cmd_valid = inject && (busy === 1'b1);
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
      if (ctrl !== 3'd0 && !(ctrl === 3'd5 && result_ready !== 1'b1)) got_q.push_back(int'(ctrl));
      if (ctrl === 3'd5) rd_cycles++;
      if (enable_act === 1'b1) acts++;
      if ($isunknown(ctrl) || ctrl > 3'd5) viol++;
      if ((ctrl inside {3'd1, 3'd2, 3'd3}) && !(data_valid && data_ready)) viol++;
      if ((data_valid && data_ready) && !(ctrl inside {3'd1, 3'd2, 3'd3})) viol++;
      if (enable_act !== (ctrl === 3'd4)) viol++;
      if (output_ctrl !== (ctrl === 3'd5) || result_valid !== (ctrl === 3'd5)) viol++;
      if ((ctrl === 3'd4 || ctrl === 3'd5) && data_ready !== 1'b0) viol++;
      if (busy !== !seen_done) viol++;
      if (cmd_ready !== seen_done) viol++;
      @(posedge clk); #1;
    end
    cmd_valid    = 1'b0;
    data_valid   = 1'b0;
    result_ready = 1'b0;

    n_checks++;
    if (!seen_done) begin
      $display("FAIL %s done_timeout got=none exp=done within %0d cycles", name, budget);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      return;
    end
    n_pass++;

    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL %s code_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
    else n_pass++;

    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (bad_idx < 0 && got_q[i] != exp_q[i]) bad_idx = i;
    n_checks++;
    if (bad_idx >= 0)
      $display("FAIL %s code_seq idx=%0d got=%0d exp=%0d", name, bad_idx, got_q[bad_idx], exp_q[bad_idx]);
    else n_pass++;

    n_checks++;
    if (acts != (nondeg ? m * act : 0))
      $display("FAIL %s act_cycles got=%0d exp=%0d", name, acts, nondeg ? m * act : 0);
    else n_pass++;

    n_checks++;
    if (rd_cycles != (nondeg ? m * (rr_stall + 1) : 0))
      $display("FAIL %s rd_cycles got=%0d exp=%0d", name, rd_cycles, nondeg ? m * (rr_stall + 1) : 0);
    else n_pass++;

    n_checks++;
    if (viol != 0) $display("FAIL %s cycle_rules violations got=%0d exp=0", name, viol);
    else n_pass++;

    if (chk_lat) begin
      n_checks++;
      if (lat != model_latency(n, m, act))
        $display("FAIL %s latency got=%0d exp=%0d", name, lat, model_latency(n, m, act));
      else n_pass++;
    end

    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL %s after_done got done=%b busy=%b rdy=%b exp done=0 busy=0 rdy=1",
               name, done, busy, cmd_ready);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    data_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({cmd_ready, ctrl, data_ready, output_ctrl, enable_act, result_valid, busy, done} !== 10'd0)
      $display("FAIL reset_outputs got=%b exp=0",
               {cmd_ready, ctrl, data_ready, output_ctrl, enable_act, result_valid, busy, done});
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) $display("FAIL reset_ready_before_edge got=%b exp=0", cmd_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready_after_edge got=%b exp=1", cmd_ready);
    else n_pass++;
    data_valid = 1'b0;
  endtask

  task automatic test_reset_midop;
    int  guard = 0;
    bit  saw_done = 1'b0;
    @(posedge clk); #1;
    cmd_len = 12'd4; cmd_vecs = 8'd1; cmd_act = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    data_valid = 1'b1;
    @(negedge clk);
    while (ctrl !== 3'd2 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (ctrl !== 3'd2) $display("FAIL midop_reach_mac got=%0d exp=2", ctrl);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({cmd_ready, ctrl, data_ready, output_ctrl, enable_act, result_valid, busy, done} !== 10'd0)
      $display("FAIL midop_reset_outputs got=%b exp=0",
               {cmd_ready, ctrl, data_ready, output_ctrl, enable_act, result_valid, busy, done});
    else n_pass++;
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    if (done === 1'b1) saw_done = 1'b1;
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL midop_release got rdy=%b busy=%b exp rdy=1 busy=0", cmd_ready, busy);
    else n_pass++;
    data_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) $display("FAIL midop_no_done got=pulse exp=none");
    else n_pass++;
  endtask

  task automatic test_basic;
    run_cmd("basic", 3, 1, 0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_stalls;
    run_cmd("stalls", 4, 2, 1, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    run_cmd("backpressure", 3, 2, 1, 0, 5, 1'b0, 1'b0);
  endtask

  task automatic test_degenerate;
    run_cmd("len_zero", 0, 3, 1, 0, 0, 1'b0, 1'b1);
    run_cmd("vecs_zero", 5, 0, 0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_busy_ignore;
    run_cmd("busy_ignore", 5, 3, 1, 0, 0, 1'b1, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      int n  = $urandom_range(1, 9);
      int m  = $urandom_range(1, 4);
      int a  = $urandom_range(0, 1);
      int dv = (i < 3) ? 0 : 2;
      int rs = (i < 3) ? 0 : $urandom_range(0, 3);
      run_cmd($sformatf("random%0d", i), n, m, a, dv, rs, 1'($urandom_range(0, 1)), (dv == 0 && rs == 0));
    end
  endtask

  task automatic test_wrap_boundary;
    run_cmd("wrap_4095", 4095, 1, 0, 0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_backpressure();
    test_degenerate();
    test_busy_ignore();
    test_random();
    test_reset_midop();
    test_wrap_boundary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
